// File: rtl/ro_period_monitor.sv
// ro_period_monitor
// Measures the period of an asynchronous ring-oscillator output in clk
// cycles. It checks each period against a programmable window, debounces
// out-of-window periods into a fail flag with hysteresis, and keeps a sticky
// copy of that flag. It also registers a clamped oscillator set-period for
// the control loop.
//
// Parameters:
//   CNT_W        width of counter, window bounds, period and set-period
//   SYNC_STAGES  synchroniser depth on ro_external (>= 2)
//   FAIL_COUNT   consecutive bad / good periods needed to set / clear fail
//
// Ports:
//   clk, rst             clock (rising edge), async active-high reset
//   en                   measurement enable
//   ro_external          asynchronous oscillator output
//   per_min, per_max     legal period window (inclusive, unsigned)
//   psi_set              requested oscillator setting
//   psi_min, psi_max     clamp bounds for the setting
//   clr_sticky           clears fail_sticky (a simultaneous set wins)
//   period_out           last measured period
//   period_valid         one-cycle strobe, period_out updated
//   timeout              one-cycle strobe, counter saturated without an edge
//   fail, fail_sticky    debounced fail and its latched copy
//   set_period           registered clamp of psi_set
module ro_period_monitor #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FAIL_COUNT  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             ro_external,
    input  logic [CNT_W-1:0] per_min,
    input  logic [CNT_W-1:0] per_max,
    input  logic [CNT_W-1:0] psi_set,
    input  logic [CNT_W-1:0] psi_min,
    input  logic [CNT_W-1:0] psi_max,
    input  logic             clr_sticky,
    output logic [CNT_W-1:0] period_out,
    output logic             period_valid,
    output logic             timeout,
    output logic             fail,
    output logic             fail_sticky,
    output logic [CNT_W-1:0] set_period
);

    localparam int               FC_W    = $clog2(FAIL_COUNT + 1);
    localparam logic [FC_W-1:0]  FC_VAL  = FC_W'(FAIL_COUNT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [FC_W-1:0]  viol_cnt;
    logic [FC_W-1:0]  good_cnt;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_d;
    logic                   rise;

    logic [CNT_W-1:0] meas;
    logic             meas_bad;
    logic [FC_W-1:0]  viol_inc;
    logic [FC_W-1:0]  good_inc;

    // Synchroniser chain followed by a registered rising-edge detector; the
    // rise pulse lasts exactly one clk cycle per synchronised edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            sync_d <= 1'b0;
            rise   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ro_external};
            sync_d <= sync_q[SYNC_STAGES-1];
            rise   <= sync_q[SYNC_STAGES-1] & ~sync_d;
        end
    end

    // A rise while cnt is saturated would need one more bit; report the
    // largest representable period instead of wrapping to zero.
    assign meas     = (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_W'(1);
    assign meas_bad = (meas < per_min) || (meas > per_max);
    assign viol_inc = (viol_cnt == FC_VAL) ? FC_VAL : viol_cnt + FC_W'(1);
    assign good_inc = (good_cnt == FC_VAL) ? FC_VAL : good_cnt + FC_W'(1);

    // Measurement FSM. Timeouts and out-of-window periods share the
    // violation path; fail changes on the same edge that completes a run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            viol_cnt     <= '0;
            good_cnt     <= '0;
            period_out   <= '0;
            period_valid <= 1'b0;
            timeout      <= 1'b0;
            fail         <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            timeout      <= 1'b0;
            if (!en) begin
                state    <= IDLE;
                cnt      <= '0;
                viol_cnt <= '0;
                good_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= ARM;
                        cnt   <= '0;
                    end
                    ARM: begin
                        if (rise) begin
                            cnt   <= '0;
                            state <= MEASURE;
                        end else if (cnt == CNT_MAX) begin
                            timeout  <= 1'b1;
                            cnt      <= '0;
                            viol_cnt <= viol_inc;
                            good_cnt <= '0;
                            if (viol_inc == FC_VAL) fail <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    MEASURE: begin
                        if (rise) begin
                            period_out   <= meas;
                            period_valid <= 1'b1;
                            cnt          <= '0;
                            if (meas_bad) begin
                                viol_cnt <= viol_inc;
                                good_cnt <= '0;
                                if (viol_inc == FC_VAL) fail <= 1'b1;
                            end else begin
                                good_cnt <= good_inc;
                                viol_cnt <= '0;
                                if (good_inc == FC_VAL) fail <= 1'b0;
                            end
                        end else if (cnt == CNT_MAX) begin
                            timeout  <= 1'b1;
                            cnt      <= '0;
                            state    <= ARM;
                            viol_cnt <= viol_inc;
                            good_cnt <= '0;
                            if (viol_inc == FC_VAL) fail <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    // Sticky flag: a set from fail takes priority over clr_sticky.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_sticky <= 1'b0;
        end else if (fail) begin
            fail_sticky <= 1'b1;
        end else if (clr_sticky) begin
            fail_sticky <= 1'b0;
        end
    end

    // Setting clamp. With inverted bounds every setting resolves to psi_max.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            set_period <= '0;
        end else if ((psi_min > psi_max) || (psi_set > psi_max)) begin
            set_period <= psi_max;
        end else if (psi_set < psi_min) begin
            set_period <= psi_min;
        end else begin
            set_period <= psi_set;
        end
    end

endmodule

// File: tb/tb_ro_period_monitor.sv
// tb_ro_period_monitor
// Self-checking bench for ro_period_monitor. A synchronous oscillator model
// drives ro_external with a chosen period. A reference model predicts, from
// the rise times, enable/reset history and window, which cycle each period
// report, timeout and fail/sticky change must appear in. Each clock cycle is
// sampled on the falling edge, compared, and then the next inputs are driven.
module tb_ro_period_monitor;

    localparam int CNT_W       = 8;
    localparam int SYNC_STAGES = 2;
    localparam int FAIL_COUNT  = 3;
    localparam int LAT         = SYNC_STAGES + 2;
    localparam int TO_SPAN     = 1 << CNT_W;

    logic             clk;
    logic             rst;
    logic             en;
    logic             ro_external;
    logic             clr_sticky;
    logic [CNT_W-1:0] per_min;
    logic [CNT_W-1:0] per_max;
    logic [CNT_W-1:0] psi_set;
    logic [CNT_W-1:0] psi_min;
    logic [CNT_W-1:0] psi_max;
    logic [CNT_W-1:0] period_out;
    logic             period_valid;
    logic             timeout;
    logic             fail;
    logic             fail_sticky;
    logic [CNT_W-1:0] set_period;

    ro_period_monitor #(
        .CNT_W      (CNT_W),
        .SYNC_STAGES(SYNC_STAGES),
        .FAIL_COUNT (FAIL_COUNT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .ro_external (ro_external),
        .per_min     (per_min),
        .per_max     (per_max),
        .psi_set     (psi_set),
        .psi_min     (psi_min),
        .psi_max     (psi_max),
        .clr_sticky  (clr_sticky),
        .period_out  (period_out),
        .period_valid(period_valid),
        .timeout     (timeout),
        .fail        (fail),
        .fail_sticky (fail_sticky),
        .set_period  (set_period)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int due;
        int per;
    } exp_t;

    bit   rst_req, en_req, clr_req, dead_req;
    int   min_req, max_req, pset_req, pmin_req, pmax_req;
    int   gen_req, gen_period, gen_ph;
    int   step, last_rise, prev_rise, rise_cnt;
    exp_t exp_q[$];
    int   viol_run, good_run;
    bit   fail_exp, sticky_exp, prev_rst, prev_clr, dead_mode;
    int   last_per_exp, set_exp_next, to_due;
    int   checks, failures;

    function automatic int clampRef(input int s, input int lo, input int hi);
        if (lo > hi) return hi;
        if (s > hi) return hi;
        if (s < lo) return lo;
        return s;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("[TB] FAIL %s step=%0d observed=%0d expected=%0d", tag, step, obs, expv);
        end
    endtask

    // Compare everything the DUT produced on the edge just passed.
    task automatic sampleCycle();
        bit   exp_valid, exp_to, ev, ev_viol;
        int   set_e;
        exp_t e;
        exp_valid = 0;
        exp_to    = 0;
        ev        = 0;
        ev_viol   = 0;
        if (prev_rst) begin
            sticky_exp   = 0;
            fail_exp     = 0;
            last_per_exp = 0;
            set_e        = 0;
        end else begin
            sticky_exp = fail_exp | (sticky_exp & ~prev_clr);
            set_e      = set_exp_next;
            if (exp_q.size() > 0 && exp_q[0].due == step) begin
                e            = exp_q.pop_front();
                exp_valid    = 1;
                last_per_exp = e.per;
                ev           = 1;
                ev_viol      = (e.per < int'(per_min)) || (e.per > int'(per_max));
            end
            if (dead_mode && step == to_due) begin
                exp_to  = 1;
                to_due += TO_SPAN;
                ev      = 1;
                ev_viol = 1;
            end
            if (ev) begin
                if (ev_viol) begin
                    viol_run++;
                    good_run = 0;
                    if (viol_run >= FAIL_COUNT) fail_exp = 1;
                end else begin
                    good_run++;
                    viol_run = 0;
                    if (good_run >= FAIL_COUNT) fail_exp = 0;
                end
            end
        end
        checkOutput("period_valid", 32'(period_valid), 32'(exp_valid));
        checkOutput("period_out", 32'(period_out), 32'(last_per_exp));
        checkOutput("timeout", 32'(timeout), 32'(exp_to));
        checkOutput("fail", 32'(fail), 32'(fail_exp));
        checkOutput("fail_sticky", 32'(fail_sticky), 32'(sticky_exp));
        checkOutput("set_period", 32'(set_period), 32'(set_e));
    endtask

    // Apply the requested inputs and advance the oscillator model.
    task automatic driveCycle();
        bit old_act, new_act;
        old_act     = en && !rst;
        new_act     = en_req && !rst_req;
        rst         = rst_req;
        en          = en_req;
        clr_sticky  = clr_req;
        per_min     = CNT_W'(min_req);
        per_max     = CNT_W'(max_req);
        psi_set     = CNT_W'(pset_req);
        psi_min     = CNT_W'(pmin_req);
        psi_max     = CNT_W'(pmax_req);
        if (rst_req) begin
            exp_q.delete();
            prev_rise    = -1;
            viol_run     = 0;
            good_run     = 0;
            fail_exp     = 0;
            last_per_exp = 0;
            dead_mode    = 0;
            gen_period   = 0;
            gen_ph       = 0;
        end else if (old_act && !new_act) begin
            exp_q.delete();
            prev_rise = -1;
            viol_run  = 0;
            good_run  = 0;
            dead_mode = 0;
        end else if (!old_act && new_act) begin
            prev_rise = (step - last_rise <= 2) ? last_rise : -1;
            dead_mode = dead_req;
            to_due    = step + TO_SPAN + 1;
        end
        if (rst_req) begin
            ro_external = 1'b0;
        end else begin
            if (gen_ph == 0) gen_period = gen_req;
            if (gen_period == 0) begin
                ro_external = 1'b0;
            end else begin
                ro_external = (gen_ph < gen_period / 2);
                if (gen_ph == 0) begin
                    if (new_act && prev_rise >= 0) exp_q.push_back('{step + LAT, step - prev_rise});
                    if (new_act) prev_rise = step;
                    last_rise = step;
                    rise_cnt++;
                end
                gen_ph = (gen_ph + 1) % gen_period;
            end
        end
        prev_rst     = rst_req;
        prev_clr     = clr_req;
        set_exp_next = clampRef(pset_req, pmin_req, pmax_req);
    endtask

    task automatic applyStimulus(input int n);
        repeat (n) begin
            @(negedge clk);
            sampleCycle();
            driveCycle();
            step++;
        end
    endtask

    task automatic runPeriods(input int p, input int n);
        int start;
        int guard;
        gen_req = p;
        start   = rise_cnt;
        guard   = 0;
        while (rise_cnt < start + n && guard < 100 * n + 100) begin
            applyStimulus(1);
            guard++;
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        step       = 0;
        last_rise  = -100;
        prev_rise  = -1;
        rise_cnt   = 0;
        gen_req    = 0;
        gen_period = 0;
        gen_ph     = 0;
        viol_run   = 0;
        good_run   = 0;
        fail_exp   = 0;
        sticky_exp = 0;
        dead_mode  = 0;
        dead_req   = 0;
        to_due     = 0;
        last_per_exp = 0;
        rst_req  = 1;
        en_req   = 0;
        clr_req  = 0;
        min_req  = 10;
        max_req  = 20;
        pset_req = 0;
        pmin_req = 0;
        pmax_req = 255;
        prev_rst = 1;
        prev_clr = 0;
        set_exp_next = 0;
        rst = 1'b1;
        en = 1'b0;
        ro_external = 1'b0;
        clr_sticky = 1'b0;
        per_min = 8'd10;
        per_max = 8'd20;
        psi_set = '0;
        psi_min = '0;
        psi_max = '1;

        $display("[TB] reset state");
        applyStimulus(3);
        rst_req = 0;

        $display("[TB] clamp");
        pmin_req = 4; pmax_req = 9;
        pset_req = 2;  applyStimulus(2);
        pset_req = 6;  applyStimulus(2);
        pset_req = 12; applyStimulus(2);
        pmin_req = 9; pmax_req = 4; pset_req = 6; applyStimulus(2);

        $display("[TB] in-window period 15");
        en_req = 1;
        runPeriods(15, 8);

        $display("[TB] violating period 8 then recovery");
        runPeriods(8, 5);
        runPeriods(15, 5);
        applyStimulus(6);
        clr_req = 1; applyStimulus(1);
        clr_req = 0; applyStimulus(3);

        $display("[TB] non-consecutive violations");
        runPeriods(8, 1);
        runPeriods(15, 1);
        runPeriods(8, 1);
        runPeriods(8, 1);
        runPeriods(15, 4);

        $display("[TB] disable and re-enable");
        en_req = 0; applyStimulus(5);
        en_req = 1; runPeriods(15, 4);
        runPeriods(8, 4);
        en_req = 0; applyStimulus(5);
        en_req = 1; runPeriods(15, 5);

        $display("[TB] randomized periods and windows");
        for (int i = 0; i < 24; i++) begin
            min_req  = $urandom_range(2, 45);
            max_req  = $urandom_range(2, 45);
            pset_req = $urandom_range(0, 255);
            pmin_req = $urandom_range(0, 255);
            pmax_req = $urandom_range(0, 255);
            clr_req  = ($urandom_range(0, 5) == 0);
            runPeriods($urandom_range(4, 40), $urandom_range(1, 4));
        end
        clr_req = 0;
        min_req = 10;
        max_req = 20;

        $display("[TB] reset mid-measurement");
        runPeriods(15, 2);
        applyStimulus(7);
        rst_req = 1; applyStimulus(3);
        rst_req = 0; runPeriods(15, 4);

        $display("[TB] dead oscillator");
        gen_req = 0; applyStimulus(20);
        en_req = 0; applyStimulus(3);
        dead_req = 1; en_req = 1;
        applyStimulus(3 * TO_SPAN + 10);
        dead_req = 0; en_req = 0; applyStimulus(3);
        en_req = 1; runPeriods(15, 5);
        gen_req = 0; applyStimulus(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ro_period_monitor.md
# ro_period_monitor

Parametrised ring-oscillator period monitor. It measures the period of an asynchronous ro_external in clk cycles and checks it against a programmable window. Out-of-window periods are debounced into a fail flag with hysteresis, and a sticky fail flag records that a failure has occurred. It also produces a clamped set-period for the oscillator control loop, and sits between the ring-oscillator macro and the status/control register block.

## Interface
Parameters:
- CNT_W, 16: width of the period counter, window bounds, period and set-period values.
- SYNC_STAGES, 2: synchroniser flops on ro_external; minimum 2.
- FAIL_COUNT, 3: consecutive violations needed to assert fail, and consecutive good periods needed to deassert it; minimum 1.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- en, input, 1: measurement enable.
- ro_external, input, 1: asynchronous oscillator output.
- per_min, input, CNT_W: smallest legal period (clk cycles).
- per_max, input, CNT_W: largest legal period (clk cycles).
- psi_set, input, CNT_W: requested oscillator setting.
- psi_min, input, CNT_W: lower clamp for the setting.
- psi_max, input, CNT_W: upper clamp for the setting.
- clr_sticky, input, 1: clears fail_sticky.
- period_out, output, CNT_W: last measured period.
- period_valid, output, 1: one-cycle strobe; period_out was updated this cycle.
- timeout, output, 1: one-cycle strobe; counter saturated without an edge.
- fail, output, 1: debounced fail.
- fail_sticky, output, 1: latched fail.
- set_period, output, CNT_W: registered clamp of psi_set.

## Operation
Edge detection:
- ro_external passes through SYNC_STAGES flops, then an edge-detect flop.
- The rise pulse is high for one clk cycle per synchronised rising edge.
- The synchroniser and edge detector run regardless of en.

States:
- IDLE, entered when en=0. cnt=0, the violation and good counters are cleared, period_valid=0, timeout=0. fail and fail_sticky hold their values.
- ARM, entered from IDLE when en=1. No period is produced. On rise: cnt<=0 and go to MEASURE. A rise in the IDLE->ARM transition cycle is ignored.
- MEASURE. cnt increments each cycle without rise.
  - On rise: period_out<=cnt+1, period_valid=1, cnt<=0.
  - Edges every P cycles give period_out=P.
- en=0 in any state moves to IDLE on the next clk.

Timeout:
- Applies in ARM or MEASURE when cnt reaches 2^CNT_W-1 without rise.
- timeout=1 for one cycle, it counts as one violation, cnt<=0, state moves to ARM.
- A dead oscillator therefore produces one violation per 2^CNT_W cycles.
- period_out is not updated on timeout.

Checking:
- A measured period is a violation when period<per_min or period>per_max. Comparison is unsigned.
- A violation increments the viol counter (saturating at FAIL_COUNT) and clears the good counter.
- An in-window period increments the good counter (saturating) and clears the viol counter.
- fail<=1 when viol reaches FAIL_COUNT; fail<=0 when good reaches FAIL_COUNT.
- If per_min>per_max, every period is a violation.

Sticky flag:
- fail_sticky sets on any cycle where fail is 1.
- clr_sticky clears it, but set wins on a simultaneous set and clear.

Clamp:
- set_period <= psi_max if psi_set>psi_max, else psi_min if psi_set<psi_min, else psi_set.
- If psi_min>psi_max, psi_max wins.
- Updated every cycle regardless of en.

## Timing
- Reset values: all outputs 0, state IDLE, cnt and counters 0, synchroniser flops 0.
- Latency from ro_external rise to rise pulse: SYNC_STAGES+1 clk edges.
- period_out and period_valid appear the clk edge after the rise pulse.
- fail changes on the same edge as the period_valid or timeout that completes the count. No extra latency.
- fail_sticky lags fail by one cycle.
- set_period has 1 cycle latency from input change.
- rst mid-measurement: all state is cleared immediately. The first rise after release (with en=1) only arms.
- ro_external high pulses narrower than one clk period may be missed. A legal input has high and low phases of at least 2 clk cycles.
- Minimum measurable period: 2.

## Test plan
- Defaults, per_min=10, per_max=20, ro period 15 clk -> after the arming edge, each period_valid shows period_out=15; fail=0.
- Ro period 8, same window -> fail rises on the edge of the 3rd period_valid and fail_sticky on the next cycle. Return to period 15 -> fail falls at the 3rd good period; fail_sticky stays 1 until clr_sticky.
- Alternating violation, good, violation, violation -> fail never asserts (consecutive rule).
- CNT_W=8, ro held low, en=1 -> timeout strobes every 256 cycles; fail asserts at the 3rd timeout; period_out unchanged.
- Period 15 running, then en=0 for 5 cycles, then en=1 -> no period_valid until the second rise after re-enable. fail holds across the disable.
- psi_min=4, psi_max=9 with psi_set = 2 / 6 / 12 -> set_period = 4 / 6 / 9. With psi_min=9, psi_max=4, psi_set=6 -> 4.
